// File: rtl/pattern_pkg.sv
// Shared encodings for the LED pattern playback controller:
// play modes, FSM states and default bus widths.
package pattern_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 5;
  localparam int DEF_DIV_W  = 24;

  localparam logic [1:0] MODE_ONCE     = 2'd0;
  localparam logic [1:0] MODE_LOOP     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RDATA = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_step_timer.sv
// Loadable down-counter that paces playback steps; zero means the
// current word has been held for its full period.
module pattern_step_timer
  import pattern_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] count_r;

  // Hold counter: load has priority, decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Pattern playback controller: steps an address window of the external
// sync-read pattern BRAM and shares its single port with a host writer.
module pattern_seq_ctrl
  import pattern_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [ADDR_W-1:0] cfg_end,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pattern_out,
  output logic              pattern_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]  DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] start_r, end_r;
  logic [1:0]        mode_r;
  logic [DIV_W-1:0]  div_r;
  logic              dir_r, dir_s;   // 1 = walking down (ping-pong only)
  logic              latch_s, capture_s, done_s, err_s;
  logic              tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [DIV_W-1:0]  tmr_val_s;
  logic              host_sel_s;

  assign tmr_val_s = (div_r == DIV_ZERO) ? DIV_ZERO : (div_r - DIV_ONE);

  pattern_step_timer #(.DIV_W(DIV_W)) u_step_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Next-state, next-address and pulse decode; stop overrides everything
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    dir_s      = dir_r;
    latch_s    = 1'b0;
    capture_s  = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
    if (cmd_stop) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_start && (cfg_start > cfg_end)) begin
            err_s = 1'b1;
          end else if (cmd_start) begin
            latch_s = 1'b1;
            addr_s  = cfg_start;
            dir_s   = 1'b0;
            state_s = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: state_s = ST_RDATA;
        ST_RDATA: begin
          capture_s  = 1'b1;
          tmr_load_s = 1'b1;
          state_s    = ST_HOLD;
        end
        ST_HOLD: begin
          if (!tmr_zero_s) begin
            tmr_dec_s = 1'b1;
          end else begin
            state_s = ST_FETCH;
            case (mode_r)
              MODE_ONCE: begin
                if (addr_r == end_r) begin
                  done_s  = 1'b1;
                  state_s = ST_IDLE;
                end else begin
                  addr_s = addr_r + ADDR_ONE;
                end
              end
              MODE_PINGPONG: begin
                // Turn around one short of each endpoint so no word repeats
                if (start_r == end_r) begin
                  addr_s = addr_r;
                end else if (!dir_r && (addr_r == end_r)) begin
                  dir_s  = 1'b1;
                  addr_s = end_r - ADDR_ONE;
                end else if (dir_r && (addr_r == start_r)) begin
                  dir_s  = 1'b0;
                  addr_s = start_r + ADDR_ONE;
                end else if (dir_r) begin
                  addr_s = addr_r - ADDR_ONE;
                end else begin
                  addr_s = addr_r + ADDR_ONE;
                end
              end
              default: begin
                if (addr_r == end_r) begin
                  addr_s = start_r;
                end else begin
                  addr_s = addr_r + ADDR_ONE;
                end
              end
            endcase
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, window registers and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      dir_r         <= 1'b0;
      start_r       <= {ADDR_W{1'b0}};
      end_r         <= {ADDR_W{1'b0}};
      mode_r        <= MODE_ONCE;
      div_r         <= DIV_ZERO;
      pattern_out   <= {DATA_W{1'b0}};
      pattern_valid <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      dir_r   <= dir_s;
      if (latch_s) begin
        start_r <= cfg_start;
        end_r   <= cfg_end;
        mode_r  <= cfg_mode;
        div_r   <= cfg_div;
      end
      if (capture_s) begin
        pattern_out <= mem_rdata;
      end
      pattern_valid <= capture_s;
      done          <= done_s;
      err           <= err_s;
    end
  end

  assign busy       = (state_r != ST_IDLE);
  assign host_sel_s = resetn && (state_r == ST_IDLE);

  // BRAM port mux: host owns the port only while idle and out of reset
  always_comb begin
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_r;
    mem_wdata = {DATA_W{1'b0}};
    if (host_sel_s) begin
      wr_ready  = 1'b1;
      mem_we    = wr_valid;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_addr  = addr_r;
    end
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl with a behavioural sync-read BRAM;
// expected cycles and words are hand-derived from the playback timing.
module tb_pattern_seq_ctrl;

  logic        clk;
  logic        resetn;
  logic [8:0]  cfg_start, cfg_end;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_div;
  logic        cmd_start, cmd_stop;
  logic        wr_valid, wr_ready;
  logic [8:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [4:0]  mem_wdata, mem_rdata;
  logic [4:0]  pattern_out;
  logic        pattern_valid, busy, done, err;

  logic [4:0] bram [0:511];

  int n_checks = 0;
  int n_pass   = 0;

  int         pv_k [$];
  logic [4:0] pv_w [$];
  int         done_cnt, done_k, idle_k, we_bad;
  int         pp_seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  pattern_seq_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_start     (cfg_start),
    .cfg_end       (cfg_end),
    .cfg_mode      (cfg_mode),
    .cfg_div       (cfg_div),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .pattern_out   (pattern_out),
    .pattern_valid (pattern_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first sync BRAM, same behaviour as the pattern memory
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [4:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    check_eq("wr_ready_idle", 32'(wr_ready), 32'd1);
    check_eq("mem_we_idle", 32'(mem_we), 32'd1);
    check_eq("mem_addr_host", 32'(mem_addr), 32'(a));
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic start_run(input logic [8:0] s, input logic [8:0] e,
                           input logic [1:0] m, input logic [23:0] d);
    cfg_start = s;
    cfg_end   = e;
    cfg_mode  = m;
    cfg_div   = d;
    cmd_start = 1'b1;
  endtask

  // Cycle k is the k-th cycle after the edge that samples cmd_start
  task automatic capture(input int ncyc, input bit hold_wr);
    pv_k.delete();
    pv_w.delete();
    done_cnt = 0;
    done_k   = -1;
    idle_k   = -1;
    we_bad   = 0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      cmd_start = 1'b0;
      if (k == 1) begin
        cfg_start = 9'h1F0;
        cfg_end   = 9'h1F8;
        cfg_mode  = 2'd0;
        cfg_div   = 24'd0;
      end
      if (hold_wr) wr_valid = 1'b1;
      #1;
      if (pattern_valid) begin
        pv_k.push_back(k);
        pv_w.push_back(pattern_out);
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (!busy && idle_k < 0) idle_k = k;
      if (busy && (wr_ready || mem_we)) we_bad++;
    end
  endtask

  task automatic check_pv(input string tag, input int i, input int k_exp, input int w_exp);
    check_eq({tag, "_cycle"}, (i < pv_k.size()) ? 32'(pv_k[i]) : 32'hFFFF_FFFF, 32'(k_exp));
    check_eq({tag, "_word"}, (i < pv_w.size()) ? 32'(pv_w[i]) : 32'hFFFF_FFFF, 32'(w_exp));
  endtask

  task automatic stop_run();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    #1;
    check_eq("stop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    cfg_start = 9'd0; cfg_end = 9'd0; cfg_mode = 2'd0; cfg_div = 24'd0;
    cmd_start = 1'b0; cmd_stop = 1'b0;
    wr_valid = 1'b1; wr_addr = 9'd3; wr_data = 5'd31;
    tick();
    tick();
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    resetn   = 1'b1;
    wr_valid = 1'b0;
    #1;
    check_eq("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_pattern", 32'(pattern_out), 32'd0);
    check_eq("post_rst_flags", 32'({pattern_valid, done, err}), 32'd0);

    for (int i = 0; i < 4; i++) host_write(9'(i), 5'(1 << i));
    host_write(9'd5, 5'h15);

    // One-shot 0..3, div 2, host write held while busy
    wr_addr = 9'd10;
    wr_data = 5'h1F;
    start_run(9'd0, 9'd3, 2'd0, 24'd2);
    capture(17, 1'b1);
    check_eq("once_count", 32'(pv_k.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_pv("once", i, 3 + 4 * i, 1 << i);
    check_eq("once_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("once_done_k", 32'(done_k), 32'd17);
    check_eq("once_idle_k", 32'(idle_k), 32'd17);
    check_eq("busy_write_blocked", 32'(we_bad), 32'd0);
    check_eq("idle_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("idle_mem_we", 32'(mem_we), 32'd1);
    check_eq("idle_mem_addr", 32'(mem_addr), 32'd10);
    tick();
    wr_valid = 1'b0;
    #1;
    check_eq("once_hold_word", 32'(pattern_out), 32'd8);
    check_eq("once_done_gone", 32'(done), 32'd0);

    // Word written at 10 is read back by playback
    start_run(9'd10, 9'd10, 2'd0, 24'd1);
    capture(6, 1'b0);
    check_pv("wr_readback", 0, 3, 5'h1F);
    check_eq("wr_readback_done", 32'(done_k), 32'd4);

    // Ping-pong 0..3, div 0
    start_run(9'd0, 9'd3, 2'd2, 24'd0);
    capture(24, 1'b0);
    check_eq("pp_count", 32'(pv_k.size()), 32'd8);
    for (int i = 0; i < 8; i++) check_pv("pp", i, 3 + 3 * i, 1 << pp_seq[i]);
    stop_run();

    // Ping-pong with a single-entry window
    start_run(9'd5, 9'd5, 2'd2, 24'd0);
    capture(12, 1'b0);
    check_eq("pp1_count", 32'(pv_k.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_pv("pp1", i, 3 + 3 * i, 5'h15);
    stop_run();

    // Loop 1..2, div 3, stop in the middle of HOLD
    start_run(9'd1, 9'd2, 2'd1, 24'd3);
    capture(19, 1'b0);
    check_eq("loop_count", 32'(pv_k.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_pv("loop", i, 3 + 5 * i, (i % 2 == 0) ? 2 : 4);
    stop_run();
    check_eq("loop_no_done", 32'(done_cnt + int'(done)), 32'd0);
    check_eq("loop_stop_word", 32'(pattern_out), 32'd4);
    check_eq("loop_stop_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("loop_stop_pv", 32'(pattern_valid), 32'd0);

    // Rejected start
    start_run(9'd7, 9'd2, 2'd0, 24'd1);
    tick();
    cmd_start = 1'b0;
    #1;
    check_eq("rej_err", 32'(err), 32'd1);
    check_eq("rej_busy", 32'(busy), 32'd0);
    tick();
    check_eq("rej_err_pulse", 32'(err), 32'd0);
    check_eq("rej_busy_after", 32'(busy), 32'd0);

    // Start and stop together
    start_run(9'd0, 9'd3, 2'd1, 24'd1);
    cmd_stop = 1'b1;
    tick();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    #1;
    check_eq("startstop_busy", 32'(busy), 32'd0);
    check_eq("startstop_err", 32'(err), 32'd0);

    // Reset in the middle of a loop run
    start_run(9'd0, 9'd3, 2'd1, 24'd1);
    capture(5, 1'b0);
    check_eq("pre_rst_pattern", 32'(pattern_out), 32'd1);
    resetn   = 1'b0;
    wr_valid = 1'b1;
    tick();
    check_eq("midrst_pattern", 32'(pattern_out), 32'd0);
    check_eq("midrst_flags", 32'({pattern_valid, busy, done, err}), 32'd0);
    check_eq("midrst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("midrst_mem_we", 32'(mem_we), 32'd0);
    resetn   = 1'b1;
    wr_valid = 1'b0;
    tick();
    check_eq("after_rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("after_rst_done", 32'(done), 32'd0);
    check_eq("after_rst_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_seq_ctrl.md
# pattern_seq_ctrl

Playback controller for the LED pattern BRAM. It walks a configurable address window of the pattern memory at a programmable step rate and presents each fetched word on a registered output for the LED driver. Three play modes are supported: one-shot, loop and ping-pong. It also arbitrates the single BRAM port between playback reads and a host write port, which is the future UART pattern loader. It sits between the Clockworks-derived clock domain and the LED output register in the SOC.

## Interface
- `ADDR_W`, 9: pattern memory address width (512 entries).
- `DATA_W`, 5: pattern word width (LED bits).
- `DIV_W`, 24: width of the step-period divider.

- `clk`  in  1: system clock (Clockworks output).
- `resetn`  in  1: synchronous, active-low reset.
- `cfg_start`  in  ADDR_W: first address of the playback window.
- `cfg_end`  in  ADDR_W: last address of the window, inclusive.
- `cfg_mode`  in  2: 0 one-shot, 1 loop, 2 ping-pong, 3 reserved (treated as loop).
- `cfg_div`  in  DIV_W: hold cycles per step; 0 is treated as 1.
- `cmd_start`  in  1: single-cycle start request.
- `cmd_stop`  in  1: single-cycle stop request.
- `wr_valid`  in  1: host write request.
- `wr_ready`  out  1: write accepted this cycle.
- `wr_addr`  in  ADDR_W: host write address.
- `wr_data`  in  DATA_W: host write data.
- `mem_addr`  out  ADDR_W: BRAM address.
- `mem_we`  out  1: BRAM write enable.
- `mem_wdata`  out  DATA_W: BRAM write data.
- `mem_rdata`  in  DATA_W: BRAM read data, valid one cycle after the address.
- `pattern_out`  out  DATA_W: current pattern word, registered.
- `pattern_valid`  out  1: one-cycle pulse when `pattern_out` updates.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse at the end of a one-shot run.
- `err`  out  1: one-cycle pulse when a start is rejected.

## Operation
- **States and transitions**
  - IDLE -> FETCH -> RDATA -> HOLD -> FETCH … (or back to IDLE).
- **IDLE**
  - `wr_ready`=1.
  - Port muxed to host: `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, `mem_we`=`wr_valid`.
  - A write completes in the same cycle.
- **cmd_start in IDLE**
  - Latch `cfg_*` into internal registers. Later `cfg_*` changes are ignored until the next start.
  - Set addr=`cfg_start`, dir=up, then go to FETCH.
  - If `cfg_start` > `cfg_end`: stay in IDLE and pulse `err`.
  - A write accepted in the same cycle lands before the first read.
- **FETCH**
  - Drive `mem_addr`=addr, `mem_we`=0.
  - `wr_ready`=0 in every non-IDLE state.
- **RDATA**
  - `pattern_out`<=`mem_rdata`, pulse `pattern_valid`.
  - Load the timer with max(`cfg_div`,1)-1, go to HOLD.
- **HOLD**
  - Decrement the timer. At zero, compute the next address.
  - One-shot, addr==end: pulse `done`, go to IDLE. `pattern_out` holds its last word.
  - Loop, addr==end: addr=start.
  - Ping-pong, up and addr==end: dir=down, addr=end-1.
  - Ping-pong, down and addr==start: dir=up, addr=start+1.
  - Ping-pong with start==end: addr stays put.
  - Otherwise addr±1 according to dir.
  - Then go to FETCH.
- **Address arithmetic**
  - Modulo 2^ADDR_W.
  - A window never wraps, because start<=end is enforced.
- **cmd_stop**
  - Has priority over `cmd_start` and over every transition.
  - Any state goes to IDLE next cycle.
  - No `done` pulse; `pattern_out` holds.
- **Reset**
  - state=IDLE.
  - `pattern_out`=0, `pattern_valid`=0, `done`=0, `err`=0, `busy`=0.
  - `mem_we`=0, `wr_ready`=0 during reset and 1 in the first cycle after.
  - Reset mid-run aborts without a `done` pulse.

## Timing
- `cmd_start` sampled at edge N:
  - FETCH during cycle N+1.
  - RDATA during N+2.
  - `pattern_valid` high in cycle N+3, with `pattern_out` updated from that cycle.
- Step period between `pattern_valid` pulses: max(`cfg_div`,1)+2 cycles.
- One-shot over L=end-start+1 words: `done` pulses in the cycle after the final HOLD expires, which is also the first cycle with `busy`=0.
- Ping-pong never repeats an endpoint word when end>start. Sequence for start=0, end=3: 0,1,2,3,2,1,0,1…
- All outputs are registered except the IDLE-state port mux (`mem_*`, `wr_ready`).

## Structure
- Shared package `pattern_pkg`:
  - Mode encodings MODE_ONCE=0, MODE_LOOP=1, MODE_PINGPONG=2.
  - State enum.
  - Default ADDR_W/DATA_W.
- One sub-module `pattern_step_timer`: a loadable down-counter with a zero flag, DIV_W wide.
- The BRAM stays external, with the same sync-read behaviour as the existing pattern memory.

## Test plan
- **Reset, then host writes:** write addrs 0..3 with 1,2,4,8 in IDLE. Required: `wr_ready`=1 and `mem_we` asserted each cycle; readback by playback matches.
- **One-shot run:** start=0, end=3, div=2. Required: `pattern_valid` at N+3, N+7, N+11, N+15 with words 1,2,4,8; `done` one cycle after the last HOLD; `busy` falls; `pattern_out`=8 holds.
- **Ping-pong:** start=0, end=3, div=0. Required: address sequence 0,1,2,3,2,1,0,1 with a period of 3 cycles; start==end=5 repeats word 5 indefinitely.
- **Loop mode, then stop mid-HOLD:** required: IDLE next cycle, no `done`, `pattern_out` unchanged, `wr_ready`=1.
- **Rejected start:** start=7, end=2. Required: `err` pulse, `busy` stays 0. Also `cmd_start` and `cmd_stop` in the same cycle: stays IDLE.
- **Write during playback:** `wr_valid` held while busy. Required: `wr_ready`=0 and no `mem_we` until IDLE, then accepted in the first IDLE cycle. Also `resetn` low mid-run: all outputs 0 next cycle.
